// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: start with a/b in, busy/done with d/bout out.
// The requester drives through master; the subtractor sits on slave.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (
    output start, a, b,
    input  busy, done, d, bout
  );

  modport slave (
    input  start, a, b,
    output busy, done, d, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor d = a - b, LSB first through one 1-bit full-subtractor cell.
// done pulses WIDTH+1 edges after start is accepted; start is only sampled in IDLE, never queued.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  serial_subtractor_if.slave io
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic cell_ina, cell_inb, cell_bin, cell_d, cell_bout;

  // full_subtractor_1 cell: ina - inb - bin
  assign cell_ina  = a_sr_q[0];
  assign cell_inb  = b_sr_q[0];
  assign cell_bin  = borrow_q;
  assign cell_d    = cell_ina ^ cell_inb ^ cell_bin;
  assign cell_bout = (~cell_ina & cell_inb) | (~(cell_ina ^ cell_inb) & cell_bin);

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    d_sr_d   = d_sr_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          a_sr_d   = io.a;
          b_sr_d   = io.b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        d_sr_d   = {cell_d, d_sr_q[WIDTH-1:1]};
        borrow_d = cell_bout;
        cnt_d    = cnt_q + CW'(1);
        // Last bit: publish the fully assembled difference and the MSB borrow together.
        if (cnt_q == CW'(WIDTH - 1)) begin
          d_d     = d_sr_d;
          bout_d  = cell_bout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_sr_q   <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      d_sr_q   <= d_sr_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.d    = d_q;
  assign io.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4 (incl. exhaustive back-to-back) and WIDTH=8.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(4)) if4 ();
  serial_subtractor_if #(.WIDTH(8)) if8 ();

  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .io(if4));
  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .io(if8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one WIDTH=4 op from IDLE; returns the edge count to done (-1 on timeout), leaves DUT in IDLE.
  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     output int edges, output logic [3:0] d, output logic bo);
    edges = -1;
    d = 'x;
    bo = 1'bx;
    if4.a = a;
    if4.b = b;
    if4.start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if4.start = 1'b0;
      if (if4.done) begin
        edges = i;
        d = if4.d;
        bo = if4.bout;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if4.start = 1'b0; if4.a = '0; if4.b = '0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    #3;
    total++;
    if ({if4.busy, if4.done, if4.d, if4.bout} !== 7'b0) begin
      bad++;
      $display("FAIL reset4: busy=%b done=%b d=%h bout=%b, want all 0", if4.busy, if4.done, if4.d, if4.bout);
    end
    total++;
    if ({if8.busy, if8.done, if8.d, if8.bout} !== 11'b0) begin
      bad++;
      $display("FAIL reset8: busy=%b done=%b d=%h bout=%b, want all 0", if8.busy, if8.done, if8.d, if8.bout);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (if4.busy !== 1'b0 || if4.done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", if4.busy, if4.done);
    end
  endtask

  task automatic test_single();
    int busy_cnt = 0, done_cnt = 0, done_at = -1;
    logic [3:0] d = '0;
    logic bo = 1'b0;
    if4.a = 4'd9;
    if4.b = 4'd3;
    if4.start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if4.start = 1'b0;
      if (if4.busy) busy_cnt++;
      if (if4.done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = i;
          d = if4.d;
          bo = if4.bout;
        end
      end
    end
    total++;
    if (done_at != 5) begin bad++; $display("FAIL single_latency: done at edge %0d, want 5", done_at); end
    total++;
    if (d !== 4'd6 || bo !== 1'b0) begin bad++; $display("FAIL single_9m3: d=%h bout=%b, want 6 0", d, bo); end
    total++;
    if (busy_cnt != 4) begin bad++; $display("FAIL single_busy: busy cycles %0d, want 4", busy_cnt); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL single_done_width: done cycles %0d, want 1", done_cnt); end
  endtask

  task automatic test_borrow();
    int e;
    logic [3:0] d;
    logic bo;
    op4(4'd3, 4'd9, e, d, bo);
    total++;
    if (e != 5 || d !== 4'hA || bo !== 1'b1) begin
      bad++; $display("FAIL borrow_3m9: edges=%0d d=%h bout=%b, want 5 a 1", e, d, bo);
    end
    op4(4'd0, 4'd1, e, d, bo);
    total++;
    if (e != 5 || d !== 4'hF || bo !== 1'b1) begin
      bad++; $display("FAIL borrow_0m1: edges=%0d d=%h bout=%b, want 5 f 1", e, d, bo);
    end
  endtask

  task automatic test_hold_equal();
    int e;
    logic [3:0] d;
    logic bo;
    if4.a = 4'd5;
    if4.b = 4'd12;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (if4.d !== 4'hF || if4.bout !== 1'b1 || if4.done !== 1'b0) begin
      bad++; $display("FAIL hold: d=%h bout=%b done=%b, want f 1 0", if4.d, if4.bout, if4.done);
    end
    op4(4'd15, 4'd15, e, d, bo);
    total++;
    if (e != 5 || d !== 4'h0 || bo !== 1'b0) begin
      bad++; $display("FAIL equal_15: edges=%0d d=%h bout=%b, want 5 0 0", e, d, bo);
    end
    op4(4'd0, 4'd0, e, d, bo);
    total++;
    if (e != 5 || d !== 4'h0 || bo !== 1'b0) begin
      bad++; $display("FAIL equal_0: edges=%0d d=%h bout=%b, want 5 0 0", e, d, bo);
    end
  endtask

  task automatic test_ignore();
    int done_at = -1, extra = 0;
    logic [3:0] d = 'x;
    logic bo = 1'bx;
    if4.a = 4'd12;
    if4.b = 4'd5;
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    tick();
    if4.a = 4'd1;
    if4.b = 4'd14;
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    total++;
    if (if4.busy !== 1'b1 || if4.d !== 4'h0 || if4.bout !== 1'b0) begin
      bad++; $display("FAIL mid_shift: busy=%b d=%h bout=%b, want 1 0 0", if4.busy, if4.d, if4.bout);
    end
    for (int i = 4; i <= 12; i++) begin
      tick();
      if (if4.done) begin
        done_at = i;
        d = if4.d;
        bo = if4.bout;
        break;
      end
    end
    total++;
    if (done_at != 5 || d !== 4'd7 || bo !== 1'b0) begin
      bad++; $display("FAIL ignore_start: edge=%0d d=%h bout=%b, want 5 7 0", done_at, d, bo);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (if4.done) extra++;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL no_queue: extra done pulses %0d, want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int e, ndone = 0;
    logic [3:0] d;
    logic bo;
    if4.a = 4'd9;
    if4.b = 4'd3;
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({if4.busy, if4.done, if4.d, if4.bout} !== 7'b0) begin
      bad++;
      $display("FAIL async_reset: busy=%b done=%b d=%h bout=%b, want all 0", if4.busy, if4.done, if4.d, if4.bout);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (if4.done || if4.busy) ndone++;
    end
    total++;
    if (ndone != 0) begin bad++; $display("FAIL aborted_op: busy/done cycles %0d, want 0", ndone); end
    op4(4'd7, 4'd2, e, d, bo);
    total++;
    if (e != 5 || d !== 4'd5 || bo !== 1'b0) begin
      bad++; $display("FAIL after_reset_7m2: edges=%0d d=%h bout=%b, want 5 5 0", e, d, bo);
    end
  endtask

  task automatic test_back_to_back4();
    logic [3:0] a, b, exp_d;
    logic exp_b, seen;
    int n;
    if4.start = 1'b1;
    for (int k = 0; k < 256; k++) begin
      a = 4'(k >> 4);
      b = 4'(k);
      exp_d = 4'(int'(a) - int'(b));
      exp_b = (a < b);
      if4.a = a;
      if4.b = b;
      seen = 1'b0;
      n = -1;
      for (int i = 1; i <= 12; i++) begin
        tick();
        if (if4.done) begin seen = 1'b1; n = i; break; end
      end
      total++;
      if (!seen || n != ((k == 0) ? 5 : 6) || if4.d !== exp_d || if4.bout !== exp_b) begin
        bad++;
        $display("FAIL b2b4 a=%0d b=%0d: d=%h bout=%b gap=%0d, want %h %b %0d",
                 a, b, if4.d, if4.bout, n, exp_d, exp_b, (k == 0) ? 5 : 6);
      end
    end
    if4.start = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back8();
    logic [7:0] a, b, exp_d;
    logic exp_b, seen;
    int n;
    logic [7:0] fa [4] = '{8'd0, 8'd255, 8'd128, 8'd1};
    logic [7:0] fb [4] = '{8'd255, 8'd0, 8'd128, 8'd2};
    if8.start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k < 4) begin
        a = fa[k];
        b = fb[k];
      end else begin
        a = 8'($urandom_range(255));
        b = 8'($urandom_range(255));
      end
      exp_d = 8'(int'(a) - int'(b));
      exp_b = (a < b);
      if8.a = a;
      if8.b = b;
      seen = 1'b0;
      n = -1;
      for (int i = 1; i <= 16; i++) begin
        tick();
        if (if8.done) begin seen = 1'b1; n = i; break; end
      end
      total++;
      if (!seen || n != ((k == 0) ? 9 : 10) || if8.d !== exp_d || if8.bout !== exp_b) begin
        bad++;
        $display("FAIL b2b8 a=%0d b=%0d: d=%h bout=%b gap=%0d, want %h %b %0d",
                 a, b, if8.d, if8.bout, n, exp_d, exp_b, (k == 0) ? 9 : 10);
      end
    end
    if8.start = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_borrow();
    test_hold_equal();
    test_ignore();
    test_reset_mid();
    test_back_to_back4();
    test_back_to_back8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
